// File: rtl/ethrx_pkg.sv
// Shared definitions for the Ethernet receive scheduler: state encoding,
// default length limits and status error bit positions.
package ethrx_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ARM     = 4'd1,
      S_CHECK   = 4'd2,
      S_FETCH   = 4'd3,
      S_WAIT    = 4'd4,
      S_LO      = 4'd5,
      S_HI      = 4'd6,
      S_STATUS  = 4'd7,
      S_RELEASE = 4'd8
   } state_t;

   localparam int DEF_MINLEN = 60;
   localparam int DEF_MAXLEN = 1514;

   localparam int ERR_LEN = 2;
   localparam int ERR_GEN = 1;
   localparam int ERR_CRC = 0;

   // Largest transfer the 9-bit word address can cover.
   localparam logic [11:0] HW_CAP = 12'd1024;

endpackage

// File: rtl/ethrx_sat_cnt.sv
// 16-bit event counter that sticks at all-ones.
// Single-cycle increment, no backpressure.
module ethrx_sat_cnt (
   input  logic        i_clk,
   input  logic        i_clr,
   input  logic        i_inc,
   output logic [15:0] o_cnt
);

   logic [15:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != 16'hFFFF))
         r_cnt <= r_cnt + 16'd1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ethrx_sched.sv
// Receive scheduler: arms the receiver, qualifies frames, streams halfwords to DMA,
// posts status and releases the receiver. Each halfword is held until dma_ack.
module ethrx_sched
   import ethrx_pkg::*;
#(
   parameter int MINLEN     = DEF_MINLEN,
   parameter int MAXLEN     = DEF_MAXLEN,
   parameter bit ACCEPT_BAD = 1'b0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        buf_post,
   input  logic        abort,
   output logic        rxena,
   input  logic        rxrdy,
   input  logic [10:0] rxcntb,
   input  logic        err_gen,
   input  logic        err_crc,
   output logic        rxdone,
   output logic [8:0]  mem_addr,
   input  logic [31:0] mem_data,
   output logic        dma_req,
   input  logic        dma_ack,
   output logic [15:0] dma_data,
   output logic        dma_last,
   output logic        st_valid,
   output logic [10:0] st_len,
   output logic [2:0]  st_err,
   output logic        st_drop,
   output logic [15:0] frm_cnt,
   output logic [15:0] drop_cnt
);

   localparam logic [10:0] L_MIN  = 11'(MINLEN);
   localparam logic [10:0] L_MAX  = 11'(MAXLEN);
   localparam logic [10:0] L_WRAP = 11'd2044;

   state_t      r_state;
   state_t      w_next;
   logic [10:0] r_len;
   logic        r_gen;
   logic        r_crc;
   logic        r_len_err;
   logic        r_drop;
   logic [11:0] r_hw_left;
   logic [8:0]  r_addr;
   logic [31:0] r_word;
   logic        r_gap;

   logic        w_len_err_in;
   logic        w_drop;
   logic [11:0] w_hw_sum;
   logic [11:0] w_hw_full;
   logic [11:0] w_hw_init;
   logic        w_last;
   logic        w_req;
   logic        w_ack;

   assign w_len_err_in = (rxcntb < L_MIN) || (rxcntb > L_MAX) || (rxcntb > L_WRAP);
   assign w_drop       = (r_len == 11'd0) ||
                         ((r_len_err || r_gen || r_crc) && (ACCEPT_BAD == 1'b0));
   assign w_hw_sum     = {1'b0, r_len} + 12'd1;
   assign w_hw_full    = {1'b0, w_hw_sum[11:1]};
   assign w_hw_init    = (w_hw_full > HW_CAP) ? HW_CAP : w_hw_full;
   assign w_last       = (r_hw_left == 12'd1);
   // r_gap forces dma_req low for the cycle after a LO acknowledge.
   assign w_req        = ((r_state == S_LO) || (r_state == S_HI)) && !r_gap;
   assign w_ack        = w_req && dma_ack;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (buf_post) w_next = S_ARM;
         S_ARM: begin
            if (rxrdy)      w_next = S_CHECK;
            else if (abort) w_next = S_IDLE;
         end
         S_CHECK:   w_next = w_drop ? S_STATUS : S_FETCH;
         S_FETCH:   w_next = S_WAIT;
         S_WAIT:    w_next = S_LO;
         S_LO:      if (w_ack) w_next = w_last ? S_STATUS : S_HI;
         S_HI:      if (w_ack) w_next = w_last ? S_STATUS : S_FETCH;
         S_STATUS:  w_next = S_RELEASE;
         S_RELEASE: if (!rxrdy) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_len     <= '0;
         r_gen     <= 1'b0;
         r_crc     <= 1'b0;
         r_len_err <= 1'b0;
         r_drop    <= 1'b0;
         r_hw_left <= '0;
         r_addr    <= '0;
         r_word    <= '0;
         r_gap     <= 1'b0;
      end else begin
         r_gap <= 1'b0;
         case (r_state)
            S_ARM: begin
               if (rxrdy) begin
                  r_len     <= rxcntb;
                  r_gen     <= err_gen;
                  r_crc     <= err_crc;
                  r_len_err <= w_len_err_in;
               end
            end
            S_CHECK: begin
               r_drop <= w_drop;
               if (!w_drop) begin
                  r_addr    <= '0;
                  r_hw_left <= w_hw_init;
               end
            end
            S_WAIT: r_word <= mem_data;
            S_LO: begin
               if (w_ack) begin
                  r_hw_left <= r_hw_left - 12'd1;
                  r_gap     <= !w_last;
               end
            end
            S_HI: begin
               if (w_ack) begin
                  r_hw_left <= r_hw_left - 12'd1;
                  if (!w_last) r_addr <= r_addr + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rxena    = (r_state == S_ARM);
      rxdone   = (r_state == S_RELEASE);
      st_valid = (r_state == S_STATUS);
      dma_req  = w_req;
      dma_last = ((r_state == S_LO) || (r_state == S_HI)) && w_last;
      dma_data = 16'd0;
      if (r_state == S_LO) dma_data = r_word[15:0];
      if (r_state == S_HI) dma_data = r_word[31:16];
      mem_addr = r_addr;
      st_len   = r_len;
      st_drop  = r_drop;
      st_err   = 3'd0;
      st_err[ERR_LEN] = r_len_err;
      st_err[ERR_GEN] = r_gen;
      st_err[ERR_CRC] = r_crc;
   end

   ethrx_sat_cnt u_frm_cnt (
      .i_clk (clk),
      .i_clr (clr),
      .i_inc ((r_state == S_STATUS) && !r_drop),
      .o_cnt (frm_cnt)
   );

   ethrx_sat_cnt u_drop_cnt (
      .i_clk (clk),
      .i_clr (clr),
      .i_inc ((r_state == S_STATUS) && r_drop),
      .o_cnt (drop_cnt)
   );

endmodule

// File: tb/tb_ethrx_sched.sv
// Bench for ethrx_sched: one instance drops bad frames, one accepts them; a byte-stream
// model of the receive buffer supplies every expected halfword, status and count.
module tb_ethrx_sched;

   localparam int MINL = 60;
   localparam int MAXL = 1514;

   logic        clk = 1'b0;
   logic        clr;
   logic        buf_post [2];
   logic        abort    [2];
   logic        rxrdy    [2];
   logic        err_gen  [2];
   logic        err_crc  [2];
   logic        dma_ack  [2];
   logic [10:0] rxcntb   [2];
   logic        rxena    [2];
   logic        rxdone   [2];
   logic        dma_req  [2];
   logic        dma_last [2];
   logic        st_valid [2];
   logic        st_drop  [2];
   logic [8:0]  mem_addr [2];
   logic [31:0] mem_data [2];
   logic [15:0] dma_data [2];
   logic [15:0] frm_cnt  [2];
   logic [15:0] drop_cnt [2];
   logic [10:0] st_len   [2];
   logic [2:0]  st_err   [2];

   logic [31:0] mem [512];
   int n_checks = 0;
   int n_pass   = 0;
   int m_frm  [2];
   int m_drop [2];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_data[0] <= mem[mem_addr[0]];
      mem_data[1] <= mem[mem_addr[1]];
   end

   ethrx_sched #(.MINLEN(MINL), .MAXLEN(MAXL), .ACCEPT_BAD(1'b0)) u0 (
      .clk(clk), .clr(clr), .buf_post(buf_post[0]), .abort(abort[0]), .rxena(rxena[0]),
      .rxrdy(rxrdy[0]), .rxcntb(rxcntb[0]), .err_gen(err_gen[0]), .err_crc(err_crc[0]),
      .rxdone(rxdone[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
      .dma_req(dma_req[0]), .dma_ack(dma_ack[0]), .dma_data(dma_data[0]),
      .dma_last(dma_last[0]), .st_valid(st_valid[0]), .st_len(st_len[0]),
      .st_err(st_err[0]), .st_drop(st_drop[0]), .frm_cnt(frm_cnt[0]), .drop_cnt(drop_cnt[0])
   );

   ethrx_sched #(.MINLEN(MINL), .MAXLEN(MAXL), .ACCEPT_BAD(1'b1)) u1 (
      .clk(clk), .clr(clr), .buf_post(buf_post[1]), .abort(abort[1]), .rxena(rxena[1]),
      .rxrdy(rxrdy[1]), .rxcntb(rxcntb[1]), .err_gen(err_gen[1]), .err_crc(err_crc[1]),
      .rxdone(rxdone[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
      .dma_req(dma_req[1]), .dma_ack(dma_ack[1]), .dma_data(dma_data[1]),
      .dma_last(dma_last[1]), .st_valid(st_valid[1]), .st_len(st_len[1]),
      .st_err(st_err[1]), .st_drop(st_drop[1]), .frm_cnt(frm_cnt[1]), .drop_cnt(drop_cnt[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] get_byte(input int b);
      logic [31:0] w;
      w = mem[(b >> 2) & 511];
      return w[8*(b & 3) +: 8];
   endfunction

   // Receiver side plus DMA responder for one frame, checked against the byte-stream model.
   task automatic run_frame(input int d, input int len, input bit gen, input bit crc,
                            input bit with_abort);
      bit          lerr, drop, holding, acked;
      int          hw_exp, hw_got, cyc, stv, amax, hold, k;
      logic [15:0] held, exp_hw, mask;
      logic [2:0]  exp_err;
      lerr    = (len < MINL) || (len > MAXL);
      drop    = (len == 0) || ((d == 0) && (lerr || gen || crc));
      hw_exp  = drop ? 0 : (len + 1) / 2;
      if (hw_exp > 1024) hw_exp = 1024;
      exp_err = {lerr, gen, crc};

      buf_post[d] = 1'b1;
      cyc = 0;
      while (rxena[d] !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      chk("arm_rxena", rxena[d], 1);
      rxcntb[d]  = 11'(len);
      err_gen[d] = gen;
      err_crc[d] = crc;
      rxrdy[d]   = 1'b1;
      abort[d]   = with_abort;
      @(negedge clk);
      abort[d]    = 1'b0;
      buf_post[d] = 1'b0;
      chk("check_rxena", rxena[d], 0);

      hw_got = 0; stv = 0; amax = 0; holding = 0; acked = 0; cyc = 0;
      hold = $urandom_range(0, 2);
      held = '0;
      while (rxdone[d] !== 1'b1 && cyc < 10000) begin
         @(negedge clk);
         cyc++;
         dma_ack[d] = 1'b0;
         if (acked) chk("req_drop", dma_req[d], 0);
         acked = 0;
         if (int'(mem_addr[d]) > amax) amax = int'(mem_addr[d]);
         if (st_valid[d] === 1'b1) begin
            stv++;
            chk("st_len", st_len[d], len);
            chk("st_err", st_err[d], exp_err);
            chk("st_drop", st_drop[d], drop);
         end
         if (dma_req[d] === 1'b1) begin
            if (!holding) begin
               held = dma_data[d];
               holding = 1;
            end else begin
               chk("hw_stable", dma_data[d], held);
            end
            if (hold > 0) begin
               hold--;
            end else begin
               mask   = ((len % 2 == 1) && (hw_got == hw_exp - 1)) ? 16'h00FF : 16'hFFFF;
               exp_hw = {get_byte(2*hw_got + 1), get_byte(2*hw_got)};
               chk("hw_data", dma_data[d] & mask, exp_hw & mask);
               chk("hw_last", dma_last[d], (hw_got == hw_exp - 1));
               dma_ack[d] = 1'b1;
               acked   = 1;
               holding = 0;
               hw_got++;
               hold = $urandom_range(0, 2);
            end
         end
      end
      chk("frame_timeout", (cyc < 10000), 1);
      chk("hw_count", hw_got, hw_exp);
      chk("status_pulses", stv, 1);
      if (!drop) chk("addr_max", amax, (hw_exp - 1) / 2);
      if (drop) m_drop[d]++; else m_frm[d]++;

      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         chk("rxdone_hold", rxdone[d], 1);
      end
      rxrdy[d] = 1'b0;
      @(negedge clk);
      chk("rxdone_clr", rxdone[d], 0);
      chk("frm_cnt", frm_cnt[d], m_frm[d]);
      chk("drop_cnt", drop_cnt[d], m_drop[d]);
   endtask

   initial begin
      int          cyc;
      int          len;
      int          r;
      for (int d = 0; d < 2; d++) begin
         buf_post[d] = 1'b0; abort[d] = 1'b0; rxrdy[d] = 1'b0; err_gen[d] = 1'b0;
         err_crc[d] = 1'b0; dma_ack[d] = 1'b0; rxcntb[d] = '0;
         m_frm[d] = 0; m_drop[d] = 0;
      end
      for (int i = 0; i < 512; i++)
         mem[i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};

      clr = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_rxena", rxena[d], 0);
         chk("rst_rxdone", rxdone[d], 0);
         chk("rst_dma_req", dma_req[d], 0);
         chk("rst_dma_data", dma_data[d], 0);
         chk("rst_mem_addr", mem_addr[d], 0);
         chk("rst_st_valid", st_valid[d], 0);
         chk("rst_frm_cnt", frm_cnt[d], 0);
         chk("rst_drop_cnt", drop_cnt[d], 0);
      end
      repeat (2) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      chk("idle_rxena", rxena[0], 0);

      // Basic frames, odd length, error and length drops on both instances.
      run_frame(0, 64, 0, 0, 0);
      run_frame(1, 64, 0, 0, 0);
      run_frame(0, 61, 0, 0, 0);
      run_frame(0, 100, 0, 1, 0);
      run_frame(1, 100, 0, 1, 0);
      run_frame(0, 40, 0, 0, 0);
      run_frame(0, 1515, 0, 0, 0);
      run_frame(1, 40, 0, 0, 0);
      run_frame(1, 1515, 0, 0, 0);
      run_frame(0, 0, 0, 0, 0);
      run_frame(1, 0, 0, 0, 0);
      run_frame(0, 1514, 1, 0, 0);
      run_frame(0, 60, 0, 0, 0);

      // Abort from ARM, then abort coinciding with rxrdy.
      buf_post[0] = 1'b1;
      cyc = 0;
      while (rxena[0] !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      chk("abort_armed", rxena[0], 1);
      abort[0] = 1'b1;
      buf_post[0] = 1'b0;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort_rxena", rxena[0], 0);
      @(negedge clk);
      chk("abort_idle", rxena[0], 0);
      run_frame(0, 64, 0, 0, 1);

      // Reset in the middle of a stalled HI halfword.
      buf_post[0] = 1'b1;
      cyc = 0;
      while (rxena[0] !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      rxcntb[0] = 11'd64;
      rxrdy[0]  = 1'b1;
      @(negedge clk);
      buf_post[0] = 1'b0;
      cyc = 0;
      while (dma_req[0] !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("clr_lo_data", dma_data[0], 16'h0100);
      dma_ack[0] = 1'b1;
      @(negedge clk);
      dma_ack[0] = 1'b0;
      cyc = 0;
      while (dma_req[0] !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("clr_hi_req", dma_req[0], 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hi_stable", dma_data[0], 16'h0302);
         chk("hi_req_held", dma_req[0], 1);
      end
      clr = 1'b1;
      #1;
      chk("clr_dma_req", dma_req[0], 0);
      chk("clr_rxena", rxena[0], 0);
      chk("clr_rxdone", rxdone[0], 0);
      chk("clr_frm0", frm_cnt[0], 0);
      chk("clr_drop0", drop_cnt[0], 0);
      chk("clr_frm1", frm_cnt[1], 0);
      chk("clr_drop1", drop_cnt[1], 0);
      m_frm[0] = 0; m_drop[0] = 0; m_frm[1] = 0; m_drop[1] = 0;
      rxrdy[0] = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      buf_post[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk("rearm_rxena", rxena[0], 1);
      abort[0] = 1'b1;
      buf_post[0] = 1'b0;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("rearm_abort", rxena[0], 0);

      // Random buffer contents and frame mix.
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      run_frame(1, 2047, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      len = $urandom_range(0, 59);
         else if (r == 1) len = $urandom_range(1515, 1600);
         else             len = $urandom_range(60, 300);
         run_frame(i % 2, len, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
